// File: rtl/gato_pkg.sv
// Shared types and constants for the tic-tac-toe judge: cell encoding, FSM states
// and the table of the eight winning lines.
package gato_pkg;

    localparam int N_CELLS = 9;
    localparam int N_LINES = 8;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_X     = 2'b01,
        CELL_O     = 2'b10
    } cell_t;

    typedef enum logic {
        PLAYER_X = 1'b0,
        PLAYER_O = 1'b1
    } player_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_SCAN,
        ST_REPORT,
        ST_GAME_OVER
    } state_t;

    // Rows, then columns, then the two diagonals; the index is the reported win_line.
    localparam logic [3:0] LINES [N_LINES][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    function automatic cell_t player_mark(input logic player);
        return player ? CELL_O : CELL_X;
    endfunction

endpackage

// File: rtl/gato_line_eval.sv
// Combinational check of one winning line: hit when all three cells of the
// selected line carry the given player's mark.
module gato_line_eval
    import gato_pkg::*;
(
    input  logic [2*N_CELLS-1:0] board,
    input  logic [2:0]           line_idx,
    input  logic                 player,
    output logic                 hit
);

    always_comb begin
        hit = 1'b1;
        for (int j = 0; j < 3; j++) begin
            if (board[2*LINES[line_idx][j] +: 2] != player_mark(player)) begin
                hit = 1'b0;
            end
        end
    end

endmodule

// File: rtl/gato_judge.sv
// Authoritative tic-tac-toe board: accepts moves, rejects illegal ones, scans the
// eight lines one per cycle for the moving player and reports win/draw.
module gato_judge
    import gato_pkg::*;
#(
    parameter logic FIRST_PLAYER = 1'b0,
    parameter bit   WIN_PULSE    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        mov_valid,
    output logic        mov_ready,
    input  logic [3:0]  mov_cell,
    input  logic        mov_player,
    output logic        reject,
    output logic [17:0] board,
    output logic        turn,
    output logic        result_valid,
    output logic [1:0]  winner,
    output logic [2:0]  win_line,
    output logic        draw,
    output logic        game_over
);

    state_t      state_q, state_d;
    logic [17:0] board_q, board_d;
    logic        turn_q, turn_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  scan_q, scan_d;
    logic [3:0]  cell_q, cell_d;
    player_t     player_q, player_d;
    logic        hit_q, hit_d;
    logic [1:0]  winner_q, winner_d;
    logic [2:0]  win_line_q, win_line_d;
    logic        draw_q, draw_d;
    logic        game_over_q, game_over_d;
    logic        reject_q, reject_d;
    logic        result_valid_q, result_valid_d;

    logic        cell_free;
    logic        move_legal;
    logic        line_hit;

    gato_line_eval u_line_eval (
        .board    (board_q),
        .line_idx (scan_q),
        .player   (player_q),
        .hit      (line_hit)
    );

    assign mov_ready = (state_q == ST_IDLE) && !game_over_q;

    // Out-of-range cells never match an index, so they read as not free.
    always_comb begin
        cell_free = 1'b0;
        for (int i = 0; i < N_CELLS; i++) begin
            if (mov_cell == 4'(i)) begin
                cell_free = (board_q[2*i +: 2] == CELL_EMPTY);
            end
        end
    end

    assign move_legal = cell_free && (mov_player == turn_q);

    always_comb begin
        state_d        = state_q;
        board_d        = board_q;
        turn_d         = turn_q;
        cnt_d          = cnt_q;
        scan_d         = scan_q;
        cell_d         = cell_q;
        player_d       = player_q;
        hit_d          = hit_q;
        winner_d       = winner_q;
        win_line_d     = win_line_q;
        draw_d         = draw_q;
        game_over_d    = game_over_q;
        reject_d       = 1'b0;
        result_valid_d = (!WIN_PULSE && state_q == ST_GAME_OVER) ? result_valid_q : 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mov_valid && mov_ready) begin
                    if (move_legal) begin
                        cell_d   = mov_cell;
                        player_d = player_t'(mov_player);
                        state_d  = ST_WRITE;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                for (int i = 0; i < N_CELLS; i++) begin
                    if (cell_q == 4'(i)) begin
                        board_d[2*i +: 2] = player_mark(player_q);
                    end
                end
                turn_d  = ~turn_q;
                cnt_d   = cnt_q + 4'd1;
                scan_d  = 3'd0;
                hit_d   = 1'b0;
                state_d = ST_SCAN;
            end
            ST_SCAN: begin
                if (line_hit) begin
                    hit_d   = 1'b1;
                    state_d = ST_REPORT;
                end else if (scan_q == 3'd7) begin
                    state_d = ST_REPORT;
                end else begin
                    scan_d = scan_q + 3'd1;
                end
            end
            ST_REPORT: begin
                result_valid_d = 1'b1;
                if (hit_q) begin
                    winner_d    = player_mark(player_q);
                    win_line_d  = scan_q;
                    game_over_d = 1'b1;
                    state_d     = ST_GAME_OVER;
                end else if (cnt_q == 4'd9) begin
                    draw_d      = 1'b1;
                    game_over_d = 1'b1;
                    state_d     = ST_GAME_OVER;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAME_OVER: begin
                state_d = ST_GAME_OVER;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new-game request wins over anything in flight, including a scan.
        if (clear) begin
            state_d        = ST_IDLE;
            board_d        = '0;
            turn_d         = FIRST_PLAYER;
            cnt_d          = '0;
            scan_d         = '0;
            hit_d          = 1'b0;
            winner_d       = 2'b00;
            win_line_d     = 3'd0;
            draw_d         = 1'b0;
            game_over_d    = 1'b0;
            reject_d       = 1'b0;
            result_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            board_q        <= '0;
            turn_q         <= FIRST_PLAYER;
            cnt_q          <= '0;
            scan_q         <= '0;
            cell_q         <= '0;
            player_q       <= PLAYER_X;
            hit_q          <= 1'b0;
            winner_q       <= 2'b00;
            win_line_q     <= 3'd0;
            draw_q         <= 1'b0;
            game_over_q    <= 1'b0;
            reject_q       <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            board_q        <= board_d;
            turn_q         <= turn_d;
            cnt_q          <= cnt_d;
            scan_q         <= scan_d;
            cell_q         <= cell_d;
            player_q       <= player_d;
            hit_q          <= hit_d;
            winner_q       <= winner_d;
            win_line_q     <= win_line_d;
            draw_q         <= draw_d;
            game_over_q    <= game_over_d;
            reject_q       <= reject_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign board        = board_q;
    assign turn         = turn_q;
    assign reject       = reject_q;
    assign result_valid = result_valid_q;
    assign winner       = winner_q;
    assign win_line     = win_line_q;
    assign draw         = draw_q;
    assign game_over    = game_over_q;

endmodule

// File: tb/tb_gato_judge.sv
// Directed bench for gato_judge with a game-level reference model checked every cycle.
module tb_gato_judge;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0;
    logic        mov_valid = 1'b0;
    logic [3:0]  mov_cell = 4'd0;
    logic        mov_player = 1'b0;
    logic        mov_ready;
    logic        reject;
    logic [17:0] board;
    logic        turn;
    logic        result_valid;
    logic [1:0]  winner;
    logic [2:0]  win_line;
    logic        draw;
    logic        game_over;

    always #5 clk = ~clk;

    gato_judge #(.FIRST_PLAYER(1'b0), .WIN_PULSE(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .mov_valid    (mov_valid),
        .mov_ready    (mov_ready),
        .mov_cell     (mov_cell),
        .mov_player   (mov_player),
        .reject       (reject),
        .board        (board),
        .turn         (turn),
        .result_valid (result_valid),
        .winner       (winner),
        .win_line     (win_line),
        .draw         (draw),
        .game_over    (game_over)
    );

    int checks = 0;
    int errors = 0;

    // Reference game state: cell code 0 empty, 1 X, 2 O.
    int         m_board [9];
    logic       exp_turn, exp_ready, exp_reject, exp_rv, exp_draw, exp_over;
    logic [1:0] exp_winner;
    logic [2:0] exp_line;
    bit         cmp_en = 1'b0;

    int win_lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                             '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [17:0] model_board();
        logic [17:0] b;
        b = '0;
        for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(m_board[i]);
        return b;
    endfunction

    function automatic int find_win(input int code);
        for (int l = 0; l < 8; l++) begin
            if (m_board[win_lines[l][0]] == code && m_board[win_lines[l][1]] == code &&
                m_board[win_lines[l][2]] == code) return l;
        end
        return -1;
    endfunction

    function automatic int filled();
        int n;
        n = 0;
        for (int i = 0; i < 9; i++) if (m_board[i] != 0) n++;
        return n;
    endfunction

    task automatic reset_model();
        for (int i = 0; i < 9; i++) m_board[i] = 0;
        exp_turn   = 1'b0;
        exp_ready  = 1'b1;
        exp_reject = 1'b0;
        exp_rv     = 1'b0;
        exp_winner = 2'b00;
        exp_line   = 3'd0;
        exp_draw   = 1'b0;
        exp_over   = 1'b0;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("board", 32'(board), 32'(model_board()));
            chk("turn", 32'(turn), 32'(exp_turn));
            chk("mov_ready", 32'(mov_ready), 32'(exp_ready));
            chk("reject", 32'(reject), 32'(exp_reject));
            chk("result_valid", 32'(result_valid), 32'(exp_rv));
            chk("winner", 32'(winner), 32'(exp_winner));
            chk("draw", 32'(draw), 32'(exp_draw));
            chk("game_over", 32'(game_over), 32'(exp_over));
            if (exp_winner != 2'b00) chk("win_line", 32'(win_line), 32'(exp_line));
        end
    end

    // Offer one move; clear_at > 0 raises clear so it is sampled that many cycles after the handshake.
    task automatic play(input int c, input int p, input int clear_at);
        bit legal;
        int r, w;
        bit full;
        @(negedge clk);
        mov_valid  = 1'b1;
        mov_cell   = 4'(c);
        mov_player = 1'(p);
        legal = 1'b0;
        if (c >= 0 && c <= 8) legal = (m_board[c] == 0) && (1'(p) == exp_turn);
        @(posedge clk);
        if (!exp_ready) begin
            @(negedge clk);
            mov_valid = 1'b0;
            return;
        end
        if (!legal) begin
            exp_reject = 1'b1;
            @(negedge clk);
            mov_valid = 1'b0;
            @(posedge clk);
            exp_reject = 1'b0;
            return;
        end
        exp_ready = 1'b0;
        r = 10;
        w = -1;
        full = 1'b0;
        for (int k = 1; k <= r + 1; k++) begin
            @(negedge clk);
            mov_valid = 1'b0;
            clear = (k == clear_at);
            @(posedge clk);
            if (k == clear_at) begin
                reset_model();
                @(negedge clk);
                clear = 1'b0;
                return;
            end
            if (k == 1) begin
                m_board[c] = p + 1;
                exp_turn = ~exp_turn;
                w = find_win(p + 1);
                r = (w >= 0) ? 3 + w : 10;
                full = (filled() == 9);
            end
            if (k == r) begin
                exp_rv = 1'b1;
                if (w >= 0) begin
                    exp_winner = 2'(p + 1);
                    exp_line   = 3'(w);
                    exp_over   = 1'b1;
                end else if (full) begin
                    exp_draw = 1'b1;
                    exp_over = 1'b1;
                end
                exp_ready = !exp_over;
            end
            if (k == r + 1) exp_rv = 1'b0;
        end
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        reset_model();
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic hold_offer(input int c, input int p, input int n);
        @(negedge clk);
        mov_valid  = 1'b1;
        mov_cell   = 4'(c);
        mov_player = 1'(p);
        repeat (n) @(posedge clk);
        @(negedge clk);
        mov_valid = 1'b0;
    endtask

    initial begin
        reset_model();
        rst = 1'b0;
        @(posedge clk);
        cmp_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("lit_reset_board", 32'(board), 32'h0);
        chk("lit_reset_ready", 32'(mov_ready), 32'h1);
        rst = 1'b1;

        // X wins on row 0
        play(0, 0, 0); play(3, 1, 0); play(1, 0, 0); play(4, 1, 0); play(2, 0, 0);
        @(negedge clk);
        chk("lit_row_winner", 32'(winner), 32'h1);
        chk("lit_row_line", 32'(win_line), 32'h0);
        chk("lit_row_over", 32'(game_over), 32'h1);
        chk("lit_row_board", 32'(board), 32'h00295);
        hold_offer(5, 1, 4);
        do_clear();

        // Illegal moves: out of range, occupied, wrong player
        play(0, 0, 0);
        play(9, 1, 0);
        play(0, 1, 0);
        play(5, 0, 0);
        @(negedge clk);
        chk("lit_illegal_board", 32'(board), 32'h1);
        chk("lit_illegal_turn", 32'(turn), 32'h1);
        do_clear();

        // Full board, no line
        play(0, 0, 0); play(1, 1, 0); play(2, 0, 0); play(4, 1, 0); play(3, 0, 0);
        play(6, 1, 0); play(5, 0, 0); play(8, 1, 0); play(7, 0, 0);
        @(negedge clk);
        chk("lit_draw", 32'(draw), 32'h1);
        chk("lit_draw_winner", 32'(winner), 32'h0);
        chk("lit_draw_over", 32'(game_over), 32'h1);
        do_clear();

        // Clear while the fifth move is being scanned
        play(0, 0, 0); play(3, 1, 0); play(1, 0, 0); play(4, 1, 0); play(8, 0, 5);
        @(negedge clk);
        chk("lit_clear_board", 32'(board), 32'h0);
        chk("lit_clear_turn", 32'(turn), 32'h0);
        repeat (10) @(posedge clk);

        // O wins on diagonal 2-4-6
        play(0, 0, 0); play(2, 1, 0); play(1, 0, 0); play(4, 1, 0); play(3, 0, 0); play(6, 1, 0);
        @(negedge clk);
        chk("lit_diag_line", 32'(win_line), 32'h7);
        chk("lit_diag_winner", 32'(winner), 32'h2);
        hold_offer(8, 0, 5);
        @(negedge clk);
        chk("lit_diag_hold_board", 32'(board[17:16]), 32'h0);

        @(negedge clk);
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
